// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO PHY controller slice.
package mdio_pkg;
   typedef enum logic [2:0] {
      INIT_RST, INIT_WAIT, INIT_AN, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE
   } state_t;
   typedef enum logic [2:0] {CTX_INIT_RST, CTX_INIT_AN, CTX_HOST, CTX_POLL} ctx_t;
   localparam logic        MDIO_READ    = 1'b0;
   localparam logic        MDIO_WRITE   = 1'b1;
   localparam logic [4:0]  REG_BMCR     = 5'd0;
   localparam logic [4:0]  REG_BMSR     = 5'd1;
   localparam int          BMSR_LINK    = 2;
   localparam int          BMSR_AN_DONE = 5;
   localparam logic [15:0] BMCR_RESET   = 16'h8000;
   localparam logic [15:0] BMCR_AN      = 16'h1200;
endpackage

// File: rtl/mdio_phy_ctrl_if.sv
// mdio_phy_ctrl_if: host request/response channel of the MDIO PHY controller.
interface mdio_phy_ctrl_if;
   logic        req, op, ready, done, err;
   logic [4:0]  regad;
   logic [15:0] wdata, rdata;
   modport master (output req, op, regad, wdata, input ready, done, err, rdata);
   modport slave  (input req, op, regad, wdata, output ready, done, err, rdata);
endinterface

// File: rtl/mdio_timer.sv
// mdio_timer: up-counter cleared by load, saturating at limit; expired once limit is reached.
module mdio_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expired
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= '0;
      else if (en && cnt < limit) cnt <= cnt + 1'b1;
   assign expired = cnt >= limit;
endmodule

// File: rtl/mdio_phy_ctrl.sv
// mdio_phy_ctrl: PHY bring-up sequencer, BMSR poller and host arbiter in front of the MDIO engine.
module mdio_phy_ctrl
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHYAD         = 5'd1,
   parameter logic [19:0] RESET_DELAY   = 20'd500000,
   parameter logic [23:0] POLL_INTERVAL = 24'd1000000,
   parameter logic [15:0] TIMEOUT       = 16'd20000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mdio_phy_ctrl_if.slave        host,
   output logic                  mdio_en,
   output logic                  mdio_op,
   output logic [4:0]            mdio_phyad,
   output logic [4:0]            mdio_regad,
   output logic [15:0]           mdio_regdata,
   input  logic                  mdio_valid,
   input  logic [15:0]           mdio_rdata,
   output logic                  init_done,
   output logic                  link_up,
   output logic                  an_done,
   output logic                  busy
);
   state_t      state;
   ctx_t        ctx;
   logic        tim_load, tim_en, tim_exp, tmo_load, tmo_en, tmo_exp, fin_ok, fin_err;
   logic [23:0] tim_limit;

   // One timer serves the post-reset settle delay and, after init, the poll interval.
   assign tim_load  = state == COMPLETE && ctx != CTX_HOST;
   assign tim_en    = init_done || state == INIT_WAIT;
   assign tim_limit = init_done ? POLL_INTERVAL : 24'(RESET_DELAY);
   assign tmo_load  = state == ISSUE || (state == WAIT_BUSY && !mdio_valid);
   assign tmo_en    = state == WAIT_BUSY || state == WAIT_DONE;
   assign fin_ok    = state == WAIT_DONE && mdio_valid;
   assign fin_err   = tmo_exp && ((state == WAIT_BUSY && mdio_valid) || (state == WAIT_DONE && !mdio_valid));
   assign host.ready = state == IDLE;
   assign busy       = state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE || state == COMPLETE;
   assign mdio_phyad = PHYAD;

   mdio_timer #(.W(24)) u_tim (
      .clk(clk), .rst_n(rst_n), .load(tim_load), .en(tim_en), .limit(tim_limit), .expired(tim_exp)
   );
   mdio_timer #(.W(16)) u_tmo (
      .clk(clk), .rst_n(rst_n), .load(tmo_load), .en(tmo_en), .limit(TIMEOUT), .expired(tmo_exp)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= INIT_RST;
         ctx          <= CTX_INIT_RST;
         mdio_en      <= 1'b0;
         mdio_op      <= MDIO_WRITE;
         mdio_regad   <= '0;
         mdio_regdata <= '0;
         host.done    <= 1'b0;
         host.err     <= 1'b0;
         host.rdata   <= '0;
         init_done    <= 1'b0;
         link_up      <= 1'b0;
         an_done      <= 1'b0;
      end else begin
         mdio_en   <= 1'b0;
         host.done <= 1'b0;
         case (state)
            // The engine may still be finishing a frame from before reset.
            INIT_RST: if (mdio_valid) begin
               ctx          <= CTX_INIT_RST;
               mdio_op      <= MDIO_WRITE;
               mdio_regad   <= REG_BMCR;
               mdio_regdata <= BMCR_RESET;
               mdio_en      <= 1'b1;
               state        <= ISSUE;
            end
            INIT_WAIT: if (tim_exp) state <= INIT_AN;
            INIT_AN: begin
               ctx          <= CTX_INIT_AN;
               mdio_op      <= MDIO_WRITE;
               mdio_regad   <= REG_BMCR;
               mdio_regdata <= BMCR_AN;
               mdio_en      <= 1'b1;
               state        <= ISSUE;
            end
            IDLE: if (host.req) begin
               ctx          <= CTX_HOST;
               mdio_op      <= host.op;
               mdio_regad   <= host.regad;
               mdio_regdata <= host.wdata;
               mdio_en      <= 1'b1;
               state        <= ISSUE;
            end else if (tim_exp) begin
               ctx          <= CTX_POLL;
               mdio_op      <= MDIO_READ;
               mdio_regad   <= REG_BMSR;
               mdio_regdata <= '0;
               mdio_en      <= 1'b1;
               state        <= ISSUE;
            end
            ISSUE: state <= WAIT_BUSY;
            WAIT_BUSY: if (!mdio_valid) state <= WAIT_DONE;
            COMPLETE: begin
               state <= ctx == CTX_INIT_RST ? INIT_WAIT : IDLE;
               if (ctx == CTX_INIT_AN) init_done <= 1'b1;
            end
            default: ;
         endcase
         // Results are published on the way into COMPLETE so host_done lands in that cycle.
         if (fin_ok || fin_err) begin
            state <= COMPLETE;
            if (ctx == CTX_HOST) begin
               host.done <= 1'b1;
               host.err  <= fin_err;
               if (fin_ok && mdio_op == MDIO_READ) host.rdata <= mdio_rdata;
            end
            if (ctx == CTX_POLL && fin_ok) begin
               link_up <= mdio_rdata[BMSR_LINK];
               an_done <= mdio_rdata[BMSR_AN_DONE];
            end
         end
      end
endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// tb_mdio_phy_ctrl: randomized host traffic against an MDIO engine/PHY model with a register scoreboard.
module tb_mdio_phy_ctrl;
   import mdio_pkg::*;
   localparam int RD  = 50;
   localparam int PI  = 400;
   localparam int TO  = 300;
   localparam int TXN = 136;

   typedef struct {int t; logic op; logic [4:0] ra; logic [15:0] d;} txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mdio_phy_ctrl_if host();
   logic        mdio_en, mdio_op, mdio_valid, init_done, link_up, an_done, busy;
   logic [4:0]  mdio_phyad, mdio_regad;
   logic [15:0] mdio_regdata, mdio_rdata;

   mdio_phy_ctrl #(
      .PHYAD(5'd1), .RESET_DELAY(20'd50), .POLL_INTERVAL(24'd400), .TIMEOUT(16'd300)
   ) dut (
      .clk(clk), .rst_n(rst_n), .host(host),
      .mdio_en(mdio_en), .mdio_op(mdio_op), .mdio_phyad(mdio_phyad), .mdio_regad(mdio_regad),
      .mdio_regdata(mdio_regdata), .mdio_valid(mdio_valid), .mdio_rdata(mdio_rdata),
      .init_done(init_done), .link_up(link_up), .an_done(an_done), .busy(busy)
   );

   int          n_vec = 0, n_err = 0, cyc = 0, en_total = 0, en_acc = 0;
   bit          stuck = 1'b0;
   txn_t        log_q[$];
   int          rise_q[$];
   logic [15:0] phy_regs[32];
   logic [15:0] exp_regs[32];
   logic [15:0] exp_rdata = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (mdio_en === 1'b1) begin
         en_total++;
         log_q.push_back('{t: cyc, op: mdio_op, ra: mdio_regad, d: mdio_regdata});
      end

   // Engine + PHY: valid drops 3 cycles after a start, returns 130 cycles later.
   initial begin
      mdio_valid = 1'b1;
      mdio_rdata = '0;
      forever begin
         @(negedge clk);
         if (mdio_en === 1'b1) begin
            logic       o;
            logic [4:0] r;
            logic [15:0] d;
            en_acc++;
            if (stuck) mdio_rdata = 16'h0000;
            else begin
               o = mdio_op; r = mdio_regad; d = mdio_regdata;
               repeat (3) @(negedge clk);
               mdio_valid = 1'b0;
               repeat (130) @(negedge clk);
               if (o == MDIO_READ) mdio_rdata = phy_regs[r];
               else phy_regs[r] = d;
               mdio_valid = 1'b1;
               rise_q.push_back(cyc);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic wait_en(input string tag, input int budget);
      int n = log_q.size();
      for (int i = 0; i < budget && log_q.size() == n; i++) @(negedge clk);
      check(tag, 32'(log_q.size() > n), 1);
   endtask

   task automatic host_txn(input logic op, input logic [4:0] ra, input logic [15:0] wd,
                           input bit tmo, output int idx);
      int t0, td;
      td = -1;
      for (int i = 0; i < 1000 && host.ready !== 1'b1; i++) @(negedge clk);
      check("host_ready", host.ready, 1);
      idx = log_q.size();
      t0  = cyc;
      host.req = 1'b1; host.op = op; host.regad = ra; host.wdata = wd;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (host.done === 1'b1) begin
            td = cyc;
            break;
         end
      end
      host.req = 1'b0;
      check("host_done_seen", host.done, 1);
      if (log_q.size() > idx) begin
         check("grant_lat", log_q[idx].t - t0, 1);
         check("en_regad", log_q[idx].ra, ra);
         check("en_op", log_q[idx].op, op);
         if (op == MDIO_WRITE) check("en_wdata", log_q[idx].d, wd);
         if (td >= 0) check("done_lat", td - log_q[idx].t, tmo ? TO + 2 : TXN - 2);
      end else check("en_seen", log_q.size(), idx + 1);
      check("host_err", host.err, tmo);
      if (!tmo && op == MDIO_READ) exp_rdata = exp_regs[ra];
      if (!tmo && op == MDIO_WRITE) exp_regs[ra] = wd;
      check("host_rdata", host.rdata, exp_rdata);
      @(negedge clk);
      check("done_pulse", host.done, 0);
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int idx, tp, n, r0;
      logic [15:0] bmsr;
      host.req = 1'b0; host.op = 1'b0; host.regad = '0; host.wdata = '0;
      foreach (phy_regs[i]) phy_regs[i] = 16'($urandom);
      phy_regs[1] = 16'h0024;
      phy_regs[2] = 16'h0141;
      exp_regs = phy_regs;
      repeat (3) @(negedge clk);
      check("rst_ready", host.ready, 0);
      check("rst_done", host.done, 0);
      check("rst_rdata", host.rdata, 0);
      check("rst_en", mdio_en, 0);
      check("rst_op", mdio_op, 1);
      check("rst_phyad", mdio_phyad, 1);
      check("rst_regad", mdio_regad, 0);
      check("rst_init", init_done, 0);
      check("rst_link", link_up, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge clk);
      check("init_done", init_done, 1);
      check("init_en_count", en_total, 2);
      if (log_q.size() >= 2 && rise_q.size() >= 1) begin
         check("init0_op", log_q[0].op, MDIO_WRITE);
         check("init0_regad", log_q[0].ra, REG_BMCR);
         check("init0_data", log_q[0].d, 16'h8000);
         check("init1_data", log_q[1].d, 16'h1200);
         check("init_gap", 32'(log_q[1].t - rise_q[0] >= RD && log_q[1].t - rise_q[0] <= RD + 10), 1);
      end
      check("ready_after_init", host.ready, 1);
      wait_en("poll1_seen", 1000);
      check("poll1_regad", log_q[$].ra, REG_BMSR);
      check("poll1_op", log_q[$].op, MDIO_READ);
      repeat (TXN) @(negedge clk);
      check("poll1_link", link_up, 1);
      check("poll1_an", an_done, 1);
      wait_en("poll2_seen", 1000);
      if (log_q.size() >= 2) check("poll_period", log_q[$].t - log_q[$-1].t, PI + TXN);
      repeat (TXN) @(negedge clk);
      host_txn(MDIO_READ, 5'd2, 16'h0000, 1'b0, idx);
      for (int k = 0; k < 8; k++)
         host_txn(1'($urandom_range(0, 1)), 5'($urandom_range(2, 31)), 16'($urandom), 1'b0, idx);
      // Host request lands in the very cycle the poll timer expires.
      wait_en("tie_poll_seen", 1200);
      tp = log_q[$].t;
      check("tie_poll_regad", log_q[$].ra, REG_BMSR);
      while (cyc < tp + PI + TXN - 1) @(negedge clk);
      host_txn(MDIO_READ, 5'd3, 16'h0000, 1'b0, idx);
      if (log_q.size() > idx) check("tie_host_first", log_q[idx].t, tp + PI + TXN);
      for (int i = 0; i < 20 && log_q.size() <= idx + 1; i++) @(negedge clk);
      if (log_q.size() > idx + 1) begin
         check("tie_poll_next", log_q[idx+1].t - log_q[idx].t, TXN);
         check("tie_poll_regad2", log_q[idx+1].ra, REG_BMSR);
      end else check("tie_poll_follow", log_q.size(), idx + 2);
      repeat (TXN) @(negedge clk);
      stuck = 1'b1;
      host_txn(MDIO_READ, 5'd4, 16'h0000, 1'b1, idx);
      wait_en("tmo_poll_seen", 1200);
      check("tmo_poll_regad", log_q[$].ra, REG_BMSR);
      repeat (TO + 8) @(negedge clk);
      check("tmo_link_kept", link_up, 1);
      check("tmo_an_kept", an_done, 1);
      check("tmo_idle", busy, 0);
      stuck = 1'b0;
      bmsr = 16'h0004;
      phy_regs[1] = bmsr;
      wait_en("poll3_seen", 1200);
      repeat (TXN) @(negedge clk);
      check("poll3_link", link_up, bmsr[BMSR_LINK]);
      check("poll3_an", an_done, bmsr[BMSR_AN_DONE]);
      // Reset in the middle of a frame the engine keeps running.
      for (int i = 0; i < 1000 && host.ready !== 1'b1; i++) @(negedge clk);
      host.req = 1'b1; host.op = MDIO_READ; host.regad = 5'd2;
      wait_en("mid_en_seen", 5);
      repeat (20) @(negedge clk);
      check("mid_busy", busy, 1);
      r0 = rise_q.size();
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_init", init_done, 0);
      check("arst_link", link_up, 0);
      check("arst_an", an_done, 0);
      check("arst_ready", host.ready, 0);
      check("arst_op", mdio_op, 1);
      host.req = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      n = log_q.size();
      for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge clk);
      check("reinit_done", init_done, 1);
      check("reinit_en_count", log_q.size() - n, 2);
      if (log_q.size() > n && rise_q.size() > r0) begin
         check("reinit_after_valid", 32'(log_q[n].t > rise_q[r0]), 1);
         check("reinit_data", log_q[n].d, 16'h8000);
      end
      check("reinit_rdata", host.rdata, exp_rdata);
      host_txn(MDIO_READ, 5'd2, 16'h0000, 1'b0, idx);
      check("no_overlap", en_total, en_acc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
